// File: rtl/wt_store_tid_tracker.sv
// Store transaction-ID tracker for the write-through L1.5 path: hands out free TIDs,
// retires them on ack, and drains all outstanding stores on a fence request.
module wt_store_tid_tracker #(
    parameter int MemTidWidth          = 2,
    parameter int MaxOutstandingStores = 7,
    localparam int NumIds              = 2 ** MemTidWidth,
    localparam int CntWidth            = $clog2(NumIds + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    output logic [MemTidWidth-1:0] req_tid_o,
    input  logic                   ack_valid_i,
    input  logic [MemTidWidth-1:0] ack_tid_i,
    input  logic                   fence_req_i,
    output logic                   fence_done_o,
    output logic [CntWidth-1:0]    outstanding_o,
    output logic                   empty_o,
    output logic                   err_o
);

    localparam int Lim = (NumIds < MaxOutstandingStores) ? NumIds : MaxOutstandingStores;
    localparam logic [CntWidth-1:0] LimCnt = CntWidth'(Lim);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // fence_state is the observable FSM state for checkers.
    logic [1:0]             fence_state;
    logic [1:0]             fence_state_d;
    logic [NumIds-1:0]      busy;
    logic [NumIds-1:0]      busy_d;
    logic [NumIds-1:0]      set_mask;
    logic [NumIds-1:0]      clr_mask;
    logic [CntWidth-1:0]    cnt;
    logic [CntWidth-1:0]    cnt_d;
    logic [MemTidWidth-1:0] free_tid;
    logic                   have_free;
    logic                   grant;
    logic                   ack_hit;
    logic                   ack_spurious;

    // Scan downward so the last hit wins: the lowest-index clear bit.
    always_comb begin
        free_tid  = '0;
        have_free = 1'b0;
        for (int i = NumIds - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_tid  = MemTidWidth'(i);
                have_free = 1'b1;
            end
        end
    end

    // Request handshake: a TID transfers on a cycle where req_valid_i && req_ready_o;
    // req_ready_o and req_tid_o depend only on registered state, never on req_valid_i.
    assign req_ready_o = (fence_state == IDLE) && (cnt < LimCnt) && have_free;
    assign req_tid_o   = free_tid;
    assign grant       = req_valid_i && req_ready_o;

    // A granted TID is clear, so an ack naming it in the same cycle lands here as spurious.
    assign ack_hit      = ack_valid_i && busy[ack_tid_i];
    assign ack_spurious = ack_valid_i && !busy[ack_tid_i];

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (grant) begin
            set_mask = NumIds'(1) << req_tid_o;
        end
        if (ack_hit) begin
            clr_mask = NumIds'(1) << ack_tid_i;
        end
        busy_d = (busy | set_mask) & ~clr_mask;
    end

    always_comb begin
        cnt_d = cnt;
        case ({grant, ack_hit})
            2'b10:   cnt_d = cnt + CntWidth'(1);
            2'b01:   cnt_d = cnt - CntWidth'(1);
            default: cnt_d = cnt;
        endcase
    end

    // DRAIN exits on the post-update count so the final ack's edge also enters DONE.
    always_comb begin
        fence_state_d = fence_state;
        case (fence_state)
            IDLE:    if (fence_req_i) fence_state_d = DRAIN;
            DRAIN:   if (cnt_d == '0) fence_state_d = DONE;
            DONE:    fence_state_d = IDLE;
            default: fence_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy        <= '0;
            cnt         <= '0;
            err_o       <= 1'b0;
            fence_state <= IDLE;
        end else begin
            busy        <= busy_d;
            cnt         <= cnt_d;
            err_o       <= ack_spurious;
            fence_state <= fence_state_d;
        end
    end

    assign fence_done_o  = (fence_state == DONE);
    assign outstanding_o = cnt;
    assign empty_o       = (cnt == '0);

endmodule
